// File: rtl/sw_reporter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared types and constants for the I2C switch reporter.
// Revision : 1.0
// ============================================================================
package i2c_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_DONE = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/sw_reporter_if.sv
`default_nettype none
// ============================================================================
// Module   : sw_reporter_if
// Brief    : Handshake between the I2C slave core (master side) and the reporter.
// Revision : 1.0
// ============================================================================
interface sw_reporter_if;
   import i2c_pkg::*;

   logic              start;
   logic              stop;
   logic              tx_req;
   logic              tx_done;
   logic              tx_ack;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_valid;

   modport master (
      output start, stop, tx_req, tx_done, tx_ack,
      input  tx_data, tx_valid
   );

   modport slave (
      input  start, stop, tx_req, tx_done, tx_ack,
      output tx_data, tx_valid
   );
endinterface
`default_nettype wire

// File: rtl/sw_reporter_sw_sync.sv
`default_nettype none
// ============================================================================
// Module   : sw_sync
// Brief    : Two-flop synchronizer for the switch bank, cleared by reset.
// Revision : 1.0
// ============================================================================
module sw_sync #(
   parameter int W = 16
) (
   input  wire logic         clk,
   input  wire logic         reset,
   input  wire logic [W-1:0] d_i,
   output logic      [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/sw_reporter.sv
`default_nettype none
// ============================================================================
// Module   : sw_reporter
// Brief    : Snapshots switches on an I2C read and streams them out LSB byte
//            first. Define SW_SYNC_EN to synchronize sw before sampling.
// Revision : 1.0
// ============================================================================
module sw_reporter
   import i2c_pkg::*;
#(
   parameter int SW_W = 16
) (
   input  wire logic            clk,
   input  wire logic            reset,
   input  wire logic [SW_W-1:0] sw_i,
   output logic                 busy_o,
   sw_reporter_if.slave         bus
);

   localparam int NUM_BYTES = SW_W / BYTE_W;
   localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   state_e            state_q, state_d;
   logic [SW_W-1:0]   snap_q, snap_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SW_W-1:0]   sw_s;
   logic [BYTE_W-1:0] byte_sel;

`ifdef SW_SYNC_EN
   sw_sync #(
      .W (SW_W)
   ) u_sw_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (sw_i),
      .q_o   (sw_s)
   );
`else
   assign sw_s = sw_i;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         snap_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
      end
   end

   // Priority: stop, then (repeated) start, then tx_done, then tx_req.
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      if (bus.stop) begin
         state_d = IDLE;
      end else if (bus.start) begin
         snap_d  = sw_s;
         idx_d   = '0;
         state_d = SEND;
      end else begin
         case (state_q)
            SEND: begin
               if (bus.tx_req) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
               if (bus.tx_done) begin
                  if (bus.tx_ack) begin
                     idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                     state_d = SEND;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Byte select is decoded from registered state only, so it holds in WAIT_DONE.
   always_comb begin
      byte_sel = '0;
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (idx_q == IDX_W'(b)) byte_sel = snap_q[b*BYTE_W +: BYTE_W];
      end
   end

   assign bus.tx_data  = byte_sel;
   assign bus.tx_valid = (state_q == SEND);
   assign busy_o       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sw_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_reporter
// Brief    : Self-checking bench for sw_reporter with a reference model.
// Revision : 1.0
// ============================================================================
module tb_sw_reporter;
   import i2c_pkg::*;

   localparam int SW_W = 16;
   localparam int NB   = SW_W / 8;

   logic            clk;
   logic            reset;
   logic [SW_W-1:0] sw;
   logic            busy;
   int              n_vec;
   int              n_err;

   sw_reporter_if bus ();

   sw_reporter #(.SW_W(SW_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .sw_i   (sw),
      .busy_o (busy),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: 0 = idle, 1 = presenting a byte, 2 = byte on the wire.
   int              m_mode;
   logic [SW_W-1:0] m_snap;
   int              m_idx;
   logic [SW_W-1:0] h0, h1, sws;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode = 0; m_snap = '0; m_idx = 0; h0 = '0; h1 = '0;
      end else begin
`ifdef SW_SYNC_EN
         sws = h1;
         h1  = h0;
         h0  = sw;
`else
         sws = sw;
`endif
         if (bus.stop) m_mode = 0;
         else if (bus.start) begin
            m_snap = sws; m_idx = 0; m_mode = 1;
         end else if (m_mode == 2 && bus.tx_done) begin
            if (bus.tx_ack) begin
               m_idx  = (m_idx + 1) % NB;
               m_mode = 1;
            end else m_mode = 0;
         end else if (m_mode == 1 && bus.tx_req) m_mode = 2;
      end
   end

   function automatic logic [7:0] m_byte();
      return 8'((m_snap >> (8 * m_idx)) & 16'h00FF);
   endfunction

   always @(negedge clk) begin
      n_vec++;
      if (bus.tx_valid !== (m_mode == 1) || busy !== (m_mode != 0)) begin
         n_err++;
         $display("FAIL model_ctrl t=%0t valid=%b busy=%b required valid=%b busy=%b",
                  $time, bus.tx_valid, busy, (m_mode == 1), (m_mode != 0));
      end
      if (m_mode != 0) begin
         n_vec++;
         if (bus.tx_data !== m_byte()) begin
            n_err++;
            $display("FAIL model_data t=%0t tx_data=%h required=%h",
                     $time, bus.tx_data, m_byte());
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk3(input string name, input logic [7:0] d, input logic v, input logic b);
      chk({name, "_data"},  bus.tx_data, d);
      chk({name, "_valid"}, {7'd0, bus.tx_valid}, {7'd0, v});
      chk({name, "_busy"},  {7'd0, busy}, {7'd0, b});
   endtask

   // Called #1 after an edge; inputs are sampled by the next edge.
   task automatic pulse(input logic s, st, rq, dn, ak);
      bus.start = s; bus.stop = st; bus.tx_req = rq; bus.tx_done = dn; bus.tx_ack = ak;
      @(posedge clk); #1;
      bus.start = 0; bus.stop = 0; bus.tx_req = 0; bus.tx_done = 0; bus.tx_ack = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      reset = 1'b1; sw = '0;
      bus.start = 0; bus.stop = 0; bus.tx_req = 0; bus.tx_done = 0; bus.tx_ack = 0;
      idle(3);
      chk3("reset", 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      sw = 16'hA55A; idle(3);

      pulse(1, 0, 0, 0, 0); chk3("start_b0", 8'h5A, 1'b1, 1'b1);
      pulse(0, 0, 1, 0, 0); chk3("wait_hold", 8'h5A, 1'b0, 1'b1);
      pulse(0, 0, 0, 1, 1); chk3("ack_b1", 8'hA5, 1'b1, 1'b1);
      sw = 16'h1234;
      pulse(0, 0, 1, 0, 0);
      pulse(0, 0, 0, 1, 1); chk3("wrap_b0", 8'h5A, 1'b1, 1'b1);
      pulse(0, 0, 1, 0, 0);
      pulse(0, 0, 0, 1, 0); chk3("nack_idle", 8'h5A, 1'b0, 1'b0);
      pulse(0, 0, 1, 0, 0);
      pulse(0, 0, 0, 1, 1); chk3("idle_ignore", 8'h5A, 1'b0, 1'b0);

      idle(3);
      pulse(1, 0, 0, 0, 0); chk3("start2", 8'h34, 1'b1, 1'b1);
      pulse(0, 0, 1, 0, 0);
      pulse(0, 1, 0, 1, 1); chk3("stop_wins", 8'h34, 1'b0, 1'b0);

      pulse(1, 0, 0, 0, 0);
      pulse(0, 0, 1, 0, 0);
      pulse(0, 0, 0, 1, 1); chk3("send_b1", 8'h12, 1'b1, 1'b1);
      sw = 16'h00FF; idle(3);
      pulse(1, 0, 0, 0, 0); chk3("rstart", 8'hFF, 1'b1, 1'b1);
      pulse(1, 1, 0, 0, 0); chk3("stop_start", 8'hFF, 1'b0, 1'b0);

      pulse(1, 0, 0, 0, 0);
      pulse(0, 0, 1, 0, 0); chk3("pre_reset", 8'hFF, 1'b0, 1'b1);
      reset = 1'b1; #1;
      chk3("async_reset", 8'h00, 1'b0, 1'b0);
      idle(2);
      reset = 1'b0;
      idle(2);

`ifdef SW_SYNC_EN
      sw = 16'hAAAA; idle(3);
      sw = 16'h5555;
      pulse(1, 0, 0, 0, 0); chk3("sync_old", 8'hAA, 1'b1, 1'b1);
      pulse(0, 1, 0, 0, 0);
      sw = 16'h0F0F; idle(2);
      pulse(1, 0, 0, 0, 0); chk3("sync_new", 8'h0F, 1'b1, 1'b1);
      pulse(0, 1, 0, 0, 0);
`endif

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sw_reporter.md
Name: sw_reporter

Overview:
- I2C-slave-side data source; the read-direction counterpart of the LED write path.
- On a read transaction, snapshots a bank of board switches and supplies it byte by byte to the I2C slave transmitter over a tx_data/tx_req/tx_done handshake.
- Sits between the switch inputs and the I2C slave core; sequences multi-byte bursts and handles master ACK/NACK and STOP.

Parameters:
- SW_W, 16, switch bank width; must be a multiple of 8 and ≥8.
- NUM_BYTES, SW_W/8, bytes per snapshot; derived, not overridden.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  1-cycle pulse from slave: address matched, R/W=1 (read); also repeated START
- stop  input  1  1-cycle pulse from slave: STOP condition detected
- sw  input  SW_W  raw switch levels
- tx_req  input  1  1-cycle pulse: slave has loaded tx_data into its shift register
- tx_done  input  1  1-cycle pulse: byte shifted out, ACK bit sampled
- tx_ack  input  1  master ACK (1) / NACK (0); valid only with tx_done
- tx_data  output  8  byte presented to slave
- tx_valid  output  1  tx_data holds a valid byte
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE; snapshot 0; idx 0; tx_data 0x00; tx_valid 0; busy 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- States: IDLE, SEND, WAIT_DONE.
- IDLE:
  - tx_valid=0.
  - On start: snapshot<=sw_s; idx<=0; go to SEND.
- SEND:
  - tx_data=snapshot[idx*8 +: 8]; tx_valid=1.
  - On tx_req: go to WAIT_DONE.
  - A tx_req in the same cycle as the SEND entry edge is not possible; it is ignored outside SEND.
- WAIT_DONE:
  - tx_valid=0; tx_data holds its value.
  - On tx_done with tx_ack=1: idx<=(idx==NUM_BYTES-1)?0:idx+1 (wraps; the snapshot is not refreshed); go to SEND.
  - On tx_done with tx_ack=0: go to IDLE. NACK ends the burst.
- Latency: start at edge N → tx_valid=1 and byte 0 on tx_data after edge N+1.
- Priority when inputs coincide in one cycle: stop > start > tx_done > tx_req.
  - stop in any state → IDLE, tx_valid=0; idx and snapshot are kept, not cleared.
  - start in SEND or WAIT_DONE (repeated START) → re-snapshot, idx<=0, SEND.
- Byte order: byte 0 = sw_s[7:0], LSB byte first.
- tx_done/tx_req outside their listed states are ignored.
- Asynchronous reset mid-burst → immediate IDLE with outputs at reset values.
- sw_s: see Optional Feature.

Optional Feature:
- Macro SW_SYNC_EN.
- Defined: sw passes through a 2-flop synchronizer (reset to 0) before sampling; sw_s = synchronized value, adding 2 cycles of input latency. A switch change reaches the snapshot only if stable ≥2 cycles before start.
- Undefined: sw_s = sw directly; the snapshot uses sw at the start edge.

Decomposition:
- Package i2c_pkg holds:
  - typedef enum state_e {IDLE, SEND, WAIT_DONE}
  - localparam BYTE_W=8
- One sub-module, sw_sync: parameterized 2-flop synchronizer with width SW_W. It is instantiated only under SW_SYNC_EN.

Test Plan:
- Reset, then sw=0xA55A, start pulse → next cycle tx_valid=1, tx_data=0x5A, busy=1.
- Continue the above: tx_req; tx_done+tx_ack=1 → tx_data=0xA5. Then tx_req; tx_done+tx_ack=1 → wraps to 0x5A. Change sw to 0x1234 mid-burst → data stays 0xA55A-derived.
- After byte 0, tx_done with tx_ack=0 → IDLE, tx_valid=0, busy=0. Further tx_req/tx_done pulses → no state change.
- During WAIT_DONE, assert stop and tx_done+ack together → IDLE; stop wins.
- In SEND on byte 1, with sw now 0x00FF, pulse start → tx_data=0xFF, idx=0. Also repeat with stop+start coincident → IDLE.
- Assert reset mid-WAIT_DONE → tx_data=0x00, tx_valid=0, busy=0 immediately.
- With SW_SYNC_EN: change sw 1 cycle before start → old value captured. Change it 3 cycles before start → new value captured.
